// File: rtl/fpu_pkg.sv
// Shared FPU_32 types: command modes, OP-FP encodings and issue FSM states.
// Also hosts the FPU_32 mode decoder so both sides agree on the encoding.
package fpu_pkg;

  typedef enum logic [2:0] {
    FPU_MUL  = 3'd0,
    FPU_ADD  = 3'd1,
    FPU_SUB  = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_IDLE = 3'd7
  } fpu_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } issue_state_t;

  localparam logic [6:0] OPC_OP_FP   = 7'b1010011;
  localparam logic [6:0] FUNCT7_ADD  = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0000100;
  localparam logic [6:0] FUNCT7_MUL  = 7'b0001000;
  localparam logic [6:0] FUNCT7_DIV  = 7'b0001100;

  function automatic logic fpu_mode_active(
    input logic [2:0] m
  );
    logic act;
    act = 1'b0;
    unique case (1'b1)
      m == FPU_MUL: act = 1'b1;
      m == FPU_ADD: act = 1'b1;
      m == FPU_SUB: act = 1'b1;
      m == FPU_DIV: act = 1'b1;
      default:      act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/fpu_op_encoder.sv
// Combinational OP-FP decoder: instruction word to FPU mode, legality, rd.
// Anything that is not one of the four supported ops comes out illegal/idle.
module fpu_op_encoder
  import fpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  mode,
  output logic        legal,
  output logic [4:0]  rd
);

  logic       opc_ok;
  logic [6:0] f7;
  logic       unused;

  assign opc_ok = instr[6:0] == OPC_OP_FP;
  assign f7     = instr[31:25];
  assign rd     = instr[11:7];
  assign unused = ^instr[24:12];

  always_comb begin
    mode  = FPU_IDLE;
    legal = 1'b0;
    unique case (1'b1)
      opc_ok && f7 == FUNCT7_ADD: begin
        mode  = FPU_ADD;
        legal = 1'b1;
      end
      opc_ok && f7 == FUNCT7_SUB: begin
        mode  = FPU_SUB;
        legal = 1'b1;
      end
      opc_ok && f7 == FUNCT7_MUL: begin
        mode  = FPU_MUL;
        legal = 1'b1;
      end
      opc_ok && f7 == FUNCT7_DIV: begin
        mode  = FPU_DIV;
        legal = 1'b1;
      end
      default: begin
        mode  = FPU_IDLE;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Initiator side of the FPU_32 command port: issues one OP-FP op at a time,
// holds operands for the op latency, returns the tagged result.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LAT_MUL = 3,
  parameter int LAT_ADD = 3,
  parameter int LAT_DIV = 28,
  parameter int CW      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_instr,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [2:0]  fpu_mode,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_illegal
);

  localparam int LAT_MAX = (1 << CW) - 1;

  if (LAT_MUL < 1 || LAT_MUL > LAT_MAX ||
      LAT_ADD < 1 || LAT_ADD > LAT_MAX ||
      LAT_DIV < 1 || LAT_DIV > LAT_MAX) begin : g_lat_chk
    $error("fpu_issue_ctrl: LAT_* outside 1..2**CW-1");
  end

  issue_state_t  state_q;
  issue_state_t  state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] lat_ld;
  logic [2:0]    mode_q;
  logic [2:0]    enc_mode;
  logic          enc_legal;
  logic [4:0]    enc_rd;
  logic          req_fire;
  logic          rsp_fire;
  logic          done;

  fpu_op_encoder u_enc (
    .instr (req_instr),
    .mode  (enc_mode),
    .legal (enc_legal),
    .rd    (enc_rd)
  );

  assign req_ready = state_q == ST_IDLE;
  assign rsp_valid = state_q == ST_RESP;
  assign req_fire  = req_valid & req_ready;
  assign rsp_fire  = rsp_valid & rsp_ready;
  assign fpu_mode  = mode_q;

  // The FPU result is sampled on the last WAIT cycle of the op latency.
  assign done = (state_q == ST_WAIT) && (cnt_q == CW'(1));

  always_comb begin
    lat_ld = CW'(LAT_ADD);
    unique case (1'b1)
      enc_mode == FPU_MUL: lat_ld = CW'(LAT_MUL);
      enc_mode == FPU_DIV: lat_ld = CW'(LAT_DIV);
      default:             lat_ld = CW'(LAT_ADD);
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_fire)
          state_d = enc_legal ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (done)
          state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q      <= FPU_IDLE;
      fpu_a       <= '0;
      fpu_b       <= '0;
      cnt_q       <= '0;
      rsp_data    <= '0;
      rsp_rd      <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      if (req_fire) begin
        rsp_rd <= enc_rd;
        if (enc_legal) begin
          mode_q      <= enc_mode;
          fpu_a       <= req_a;
          fpu_b       <= req_b;
          cnt_q       <= lat_ld;
          rsp_illegal <= 1'b0;
        end else begin
          rsp_data    <= '0;
          rsp_illegal <= 1'b1;
        end
      end
      if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q - CW'(1);
        if (done) begin
          rsp_data <= fpu_result;
          mode_q   <= FPU_IDLE;
        end
      end
      if (rsp_fire)
        rsp_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: FPU_32 stand-in, transaction-level model,
// directed literal cases and a randomized run.
module tb_fpu_issue_ctrl;

  localparam int LAT_MUL = 3;
  localparam int LAT_ADD = 3;
  localparam int LAT_DIV = 28;
  localparam int CW      = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_instr = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  fpu_mode;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_illegal;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .LAT_MUL (LAT_MUL),
    .LAT_ADD (LAT_ADD),
    .LAT_DIV (LAT_DIV),
    .CW      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_instr   (req_instr),
    .req_a       (req_a),
    .req_b       (req_b),
    .fpu_mode    (fpu_mode),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_result  (fpu_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_rd      (rsp_rd),
    .rsp_illegal (rsp_illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [2:0] m);
    if (m == 3'd0) return LAT_MUL;
    if (m == 3'd3) return LAT_DIV;
    return LAT_ADD;
  endfunction

  // Known FP32 results for the directed cases, a hash for everything else.
  function automatic logic [31:0] fpu_fn(input logic [2:0] m,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case ({m, a, b})
      {3'd1, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {3'd2, 32'h3F800000, 32'h40000000}: return 32'hBF800000;
      {3'd0, 32'h40000000, 32'h40400000}: return 32'h40C00000;
      {3'd3, 32'h40C00000, 32'h40000000}: return 32'h40400000;
      default:
        return (a ^ {b[15:0], b[31:16]}) + {29'd0, m} * 32'h9E3779B9;
    endcase
  endfunction

  // FPU_32 stand-in: result valid only once inputs have been stable
  // long enough; before that it returns garbage.
  logic [66:0] fpu_cur;
  logic [66:0] fpu_held = '0;
  int          fpu_age = 0;
  int          cur_age;

  assign fpu_cur = {fpu_mode, fpu_a, fpu_b};

  always @(posedge clk) begin
    if (fpu_mode != 3'd7)
      fpu_age <= (fpu_cur == fpu_held) ? fpu_age + 1 : 1;
    else
      fpu_age <= 0;
    fpu_held <= fpu_cur;
  end

  always_comb begin
    cur_age = (fpu_cur == fpu_held) ? fpu_age : 0;
    fpu_result = 32'hDEADBEEF;
    if (fpu_mode != 3'd7 && cur_age >= lat_of(fpu_mode) - 1)
      fpu_result = fpu_fn(fpu_mode, fpu_a, fpu_b);
  end

  // Transaction model: an accepted op answers LAT+1 cycles later
  // (1 cycle if illegal) and holds until the consumer takes it.
  logic        d_legal;
  logic [2:0]  d_mode;
  int          d_lat;

  always_comb begin
    d_legal = 1'b0;
    d_mode  = 3'd7;
    d_lat   = 0;
    if (req_instr[6:0] == 7'b1010011) begin
      case (req_instr[31:25])
        7'b0000000: begin d_legal = 1'b1; d_mode = 3'd1; d_lat = LAT_ADD; end
        7'b0000100: begin d_legal = 1'b1; d_mode = 3'd2; d_lat = LAT_ADD; end
        7'b0001000: begin d_legal = 1'b1; d_mode = 3'd0; d_lat = LAT_MUL; end
        7'b0001100: begin d_legal = 1'b1; d_mode = 3'd3; d_lat = LAT_DIV; end
        default: ;
      endcase
    end
  end

  int          cyc = 0;
  int          m_rsp = 0;
  bit          m_busy = 1'b0;
  bit          m_legal = 1'b0;
  bit          started = 1'b0;
  logic [2:0]  m_mode = 3'd7;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      started <= 1'b1;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_legal <= d_legal;
        m_mode  <= d_mode;
        m_a     <= req_a;
        m_b     <= req_b;
        m_rd    <= req_instr[11:7];
        m_data  <= d_legal ? fpu_fn(d_mode, req_a, req_b) : 32'h0;
        m_rsp   <= cyc + 1 + (d_legal ? d_lat : 0);
      end
    end else if (cyc >= m_rsp && rsp_ready) begin
      m_busy <= 1'b0;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_req_ready", req_ready, !m_busy);
      chk("m_rsp_valid", rsp_valid, m_busy && cyc >= m_rsp);
      if (m_busy && m_legal && cyc < m_rsp) begin
        chk("m_fpu_mode", fpu_mode, m_mode);
        chk("m_fpu_a", fpu_a, m_a);
        chk("m_fpu_b", fpu_b, m_b);
      end else begin
        chk("m_fpu_mode_idle", fpu_mode, 3'd7);
      end
      if (m_busy && cyc >= m_rsp) begin
        chk("m_rsp_data", rsp_data, m_data);
        chk("m_rsp_illegal", rsp_illegal, !m_legal);
        if (m_legal)
          chk("m_rsp_rd", rsp_rd, m_rd);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge
  // where the DUT is idle again.
  task automatic run_op(input string nm,
                        input logic [31:0] ins,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp_d,
                        input logic exp_ill,
                        input logic [2:0] exp_mode,
                        input int exp_lat,
                        input int hold);
    int n;
    chk({nm, " req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_instr = ins;
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 100) begin
      chk({nm, " mode"}, fpu_mode, exp_mode);
      @(negedge clk);
      n++;
    end
    chk({nm, " lat"}, n, exp_lat);
    chk({nm, " resp_mode"}, fpu_mode, 3'd7);
    chk({nm, " data"}, rsp_data, exp_d);
    chk({nm, " illegal"}, rsp_illegal, exp_ill);
    if (!exp_ill)
      chk({nm, " rd"}, rsp_rd, ins[11:7]);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk({nm, " bp_valid"}, rsp_valid, 1'b1);
      chk({nm, " bp_ready"}, req_ready, 1'b0);
      chk({nm, " bp_data"}, rsp_data, exp_d);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, " done_valid"}, rsp_valid, 1'b0);
    chk({nm, " done_ready"}, req_ready, 1'b1);
    chk({nm, " done_illegal"}, rsp_illegal, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    logic [6:0] opc;
    int r;
    r   = $urandom_range(0, 9);
    opc = 7'b1010011;
    f7  = 7'h00;
    case (r)
      0, 1:    f7 = 7'b0000000;
      2, 3:    f7 = 7'b0000100;
      4, 5:    f7 = 7'b0001000;
      6:       f7 = 7'b0001100;
      7, 8:    f7 = 7'($urandom);
      default: opc = 7'b1010011 ^ 7'($urandom_range(1, 127));
    endcase
    return {f7, 13'($urandom), 5'($urandom), opc};
  endfunction

  initial begin
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mode", fpu_mode, 3'd7);
    chk("rst_a", fpu_a, 32'h0);
    chk("rst_b", fpu_b, 32'h0);
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_data", rsp_data, 32'h0);
    chk("rst_rd", rsp_rd, 5'd0);
    chk("rst_illegal", rsp_illegal, 1'b0);
    rst = 1'b1;

    run_op("add", {7'h00, 13'h0, 5'd5, 7'h53}, 32'h3F800000,
           32'h40000000, 32'h40400000, 1'b0, 3'd1, LAT_ADD + 1, 0);
    run_op("sub", {7'h04, 13'h0, 5'd6, 7'h53}, 32'h3F800000,
           32'h40000000, 32'hBF800000, 1'b0, 3'd2, LAT_ADD + 1, 0);
    run_op("mul", {7'h08, 13'h0, 5'd7, 7'h53}, 32'h40000000,
           32'h40400000, 32'h40C00000, 1'b0, 3'd0, LAT_MUL + 1, 0);
    run_op("div", {7'h0C, 13'h0, 5'd8, 7'h53}, 32'h40C00000,
           32'h40000000, 32'h40400000, 1'b0, 3'd3, LAT_DIV + 1, 0);
    run_op("ill", {7'h10, 13'h0, 5'd9, 7'h53}, 32'h1,
           32'h2, 32'h0, 1'b1, 3'd7, 1, 0);
    run_op("opc", {7'h00, 13'h0, 5'd3, 7'h33}, 32'h3F800000,
           32'h40000000, 32'h0, 1'b1, 3'd7, 1, 0);
    run_op("bp", {7'h00, 13'h0, 5'd10, 7'h53}, 32'h3F800000,
           32'h40000000, 32'h40400000, 1'b0, 3'd1, LAT_ADD + 1, 10);

    req_valid = 1'b1;
    req_instr = {7'h0C, 13'h0, 5'd11, 7'h53};
    req_a     = 32'h40C00000;
    req_b     = 32'h40000000;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rdiv_busy_mode", fpu_mode, 3'd3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rdiv_mode", fpu_mode, 3'd7);
    chk("rdiv_valid", rsp_valid, 1'b0);
    chk("rdiv_ready", req_ready, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("rdiv_stale", rsp_valid, 1'b0);
    end

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) != 0);
      req_valid = 1'($urandom_range(0, 1));
      req_instr = rand_instr();
      req_a     = $urandom;
      req_b     = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
